// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the serial packet receiver controller: FSM state
// encoding, error codes and the default start-of-frame byte.
package rx_pkt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CSUM    = 3'd3,
      ST_DRAIN   = 3'd4
   } rx_state_e;

   localparam logic [2:0] ERR_PARITY  = 3'd0;
   localparam logic [2:0] ERR_LEN     = 3'd1;
   localparam logic [2:0] ERR_CSUM    = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_OVERRUN = 3'd4;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   // Running checksum accumulation; 8-bit result wraps modulo 256.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
      return acc + data;
   endfunction

endpackage

// File: rtl/rx_pkt_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port. No reset; entries are meaningless until
// written by the current frame.
module rx_pkt_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // Store one payload byte per accepted receiver byte.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/serial_rx_packet_ctrl.sv
// Packet-level controller behind the serial parity receiver. Hunts for SOF,
// walks each frame through length, payload and checksum, buffers the payload
// and drains verified payloads over a valid/ready stream. Every frame fault
// produces a one-cycle err_pulse with a sticky err_code.
module serial_rx_packet_ctrl
   import rx_pkt_pkg::*;
#(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF         = SOF_DEFAULT,
   parameter int         TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_perr,
   output logic [7:0] pkt_data,
   output logic       pkt_valid,
   input  logic       pkt_ready,
   output logic       pkt_last,
   output logic       err_pulse,
   output logic [2:0] err_code,
   output logic       busy
);

   localparam int              AW        = $clog2(MAX_LEN);
   localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

   rx_state_e     state_q;
   logic [7:0]    len_q;
   logic [7:0]    idx_q;
   logic [7:0]    rd_idx_q;
   logic [7:0]    sum_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    pkt_data_q;
   logic          pkt_valid_q;
   logic          pkt_last_q;
   logic          err_pulse_q;
   logic [2:0]    err_code_q;
   logic          busy_q;

   logic          in_frame_s;
   logic          tmo_expire_s;
   logic          buf_we_s;
   logic [AW-1:0] rd_addr_s;
   logic [7:0]    rd_data_s;
   logic [7:0]    sum_chk_s;

   // Frame-phase decode, timeout expiry, buffer write strobe and read address.
   // The read port looks one beat ahead so the next beat can be registered
   // on the handshake edge without a bubble.
   always_comb begin
      in_frame_s   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
      tmo_expire_s = in_frame_s && !rx_valid && (tmo_q == TMO_LAST);
      buf_we_s     = (state_q == ST_PAYLOAD) && rx_valid && !rx_perr;
      sum_chk_s    = csum_add(sum_q, rx_byte);
      if (state_q == ST_DRAIN) begin
         rd_addr_s = rd_idx_q[AW-1:0] + AW'(1);
      end else begin
         rd_addr_s = '0;
      end
   end

   rx_pkt_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .we_i    (buf_we_s),
      .waddr_i (idx_q[AW-1:0]),
      .wdata_i (rx_byte),
      .raddr_i (rd_addr_s),
      .rdata_o (rd_data_s)
   );

   // Inter-byte idle counter: runs inside a frame, clears on every byte and on expiry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_q <= '0;
      end else if (in_frame_s && !rx_valid && !tmo_expire_s) begin
         tmo_q <= tmo_q + TW'(1);
      end else begin
         tmo_q <= '0;
      end
   end

   // Frame sequencer with registered stream and error outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         len_q       <= 8'd0;
         idx_q       <= 8'd0;
         rd_idx_q    <= 8'd0;
         sum_q       <= 8'd0;
         pkt_data_q  <= 8'd0;
         pkt_valid_q <= 1'b0;
         pkt_last_q  <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= 3'd0;
         busy_q      <= 1'b0;
      end else begin
         err_pulse_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_valid && !rx_perr && (rx_byte == SOF)) begin
                  state_q <= ST_LEN;
                  busy_q  <= 1'b1;
               end
            end
            ST_LEN: begin
               if (rx_valid && rx_perr) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_PARITY;
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
               end else if (rx_valid) begin
                  if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
                     err_pulse_q <= 1'b1;
                     err_code_q  <= ERR_LEN;
                     state_q     <= ST_IDLE;
                     busy_q      <= 1'b0;
                  end else begin
                     len_q   <= rx_byte;
                     sum_q   <= rx_byte;
                     idx_q   <= 8'd0;
                     state_q <= ST_PAYLOAD;
                  end
               end else if (tmo_expire_s) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_TIMEOUT;
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
               end
            end
            ST_PAYLOAD: begin
               if (rx_valid && rx_perr) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_PARITY;
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
               end else if (rx_valid) begin
                  sum_q <= sum_chk_s;
                  if (idx_q == (len_q - 8'd1)) begin
                     state_q <= ST_CSUM;
                  end else begin
                     idx_q <= idx_q + 8'd1;
                  end
               end else if (tmo_expire_s) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_TIMEOUT;
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
               end
            end
            ST_CSUM: begin
               if (rx_valid && rx_perr) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_PARITY;
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
               end else if (rx_valid) begin
                  if (sum_chk_s == 8'h00) begin
                     // Present beat 0 straight away; rd_addr_s is 0 outside DRAIN.
                     state_q     <= ST_DRAIN;
                     rd_idx_q    <= 8'd0;
                     pkt_data_q  <= rd_data_s;
                     pkt_valid_q <= 1'b1;
                     pkt_last_q  <= (len_q == 8'd1);
                  end else begin
                     err_pulse_q <= 1'b1;
                     err_code_q  <= ERR_CSUM;
                     state_q     <= ST_IDLE;
                     busy_q      <= 1'b0;
                  end
               end else if (tmo_expire_s) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_TIMEOUT;
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // Bytes arriving while draining are dropped; the buffer is left intact.
               if (rx_valid) begin
                  err_pulse_q <= 1'b1;
                  err_code_q  <= ERR_OVERRUN;
               end
               if (pkt_valid_q && pkt_ready) begin
                  if (pkt_last_q) begin
                     state_q     <= ST_IDLE;
                     busy_q      <= 1'b0;
                     pkt_valid_q <= 1'b0;
                     pkt_last_q  <= 1'b0;
                  end else begin
                     rd_idx_q   <= rd_idx_q + 8'd1;
                     pkt_data_q <= rd_data_s;
                     pkt_last_q <= ((rd_idx_q + 8'd2) == len_q);
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               pkt_valid_q <= 1'b0;
               pkt_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pkt_data  = pkt_data_q;
   assign pkt_valid = pkt_valid_q;
   assign pkt_last  = pkt_last_q;
   assign err_pulse = err_pulse_q;
   assign err_code  = err_code_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_rx_packet_ctrl.sv
// Self-checking bench for serial_rx_packet_ctrl. A frame-level reference
// model collects each frame's bytes and judges it as a whole; a negedge
// monitor records delivered beats and error pulses for comparison.
module tb_serial_rx_packet_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_perr;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       pkt_ready;
   logic       pkt_last;
   logic       err_pulse;
   logic [2:0] err_code;
   logic       busy;

   serial_rx_packet_ctrl #(
      .MAX_LEN     (16),
      .SOF         (8'hA5),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .rx_perr   (rx_perr),
      .pkt_data  (pkt_data),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_last  (pkt_last),
      .err_pulse (err_pulse),
      .err_code  (err_code),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] got_beats[$];
   logic [8:0] exp_beats[$];
   logic [2:0] got_errs[$];
   logic [2:0] exp_errs[$];
   bit         m_in = 1'b0;
   logic [7:0] m_frame[$];
   logic       stall_q = 1'b0;
   logic [8:0] stall_beat = 9'd0;

   // Monitor: record handshakes and error pulses, check stall stability.
   always @(negedge clk) begin
      if (!rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            checks++;
            if (pkt_valid !== 1'b1 || {pkt_last, pkt_data} !== stall_beat) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b beat=%h, expected valid=1 beat=%h",
                        pkt_valid, {pkt_last, pkt_data}, stall_beat);
            end
         end
         if (pkt_valid && pkt_ready) got_beats.push_back({pkt_last, pkt_data});
         if (err_pulse) got_errs.push_back(err_code);
         stall_q    = pkt_valid && !pkt_ready;
         stall_beat = {pkt_last, pkt_data};
      end
   end

   // Reference model: gather a frame after SOF, judge it once complete.
   task automatic model_feed(input logic [7:0] b, input bit perr);
      int sum;
      int len;
      if (!m_in) begin
         if (!perr && b == 8'hA5) begin
            m_in = 1'b1;
            m_frame.delete();
         end
      end else if (perr) begin
         exp_errs.push_back(3'd0);
         m_in = 1'b0;
      end else begin
         m_frame.push_back(b);
         len = int'(m_frame[0]);
         if (m_frame.size() == 1) begin
            if (len == 0 || len > 16) begin
               exp_errs.push_back(3'd1);
               m_in = 1'b0;
            end
         end else if (m_frame.size() == len + 2) begin
            sum = 0;
            foreach (m_frame[i]) sum += int'(m_frame[i]);
            if (sum % 256 == 0) begin
               for (int i = 1; i <= len; i++) exp_beats.push_back({(i == len), m_frame[i]});
            end else begin
               exp_errs.push_back(3'd2);
            end
            m_in = 1'b0;
         end
      end
   endtask

   // Drive one receiver byte for one cycle; returns #1 after its sampling edge.
   task automatic send_byte(input logic [7:0] b, input bit perr);
      rx_byte  = b;
      rx_perr  = perr;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_perr  = 1'b0;
      model_feed(b, perr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Send a byte list with receiver-like spacing.
   task automatic send_list(input logic [7:0] bytes[$]);
      foreach (bytes[i]) begin
         send_byte(bytes[i], 1'b0);
         if (i != bytes.size() - 1) idle(10);
      end
   endtask

   // Wait (bounded) for busy to drop, optionally randomizing pkt_ready.
   task automatic wait_idle(input bit rnd);
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (!busy) done = 1'b1;
         else begin
            if (rnd) pkt_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_idle: busy=%0b after 400 cycles, expected 0", busy);
      end
      pkt_ready = 1'b1;
      idle(2);
   endtask

   task automatic test_reset();
      rst = 1'b0; rx_byte = 8'd0; rx_valid = 1'b0; rx_perr = 1'b0; pkt_ready = 1'b1;
      idle(3);
      checks++;
      if ({pkt_data, pkt_valid, pkt_last, err_pulse, err_code} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h v=%0b l=%0b ep=%0b ec=%0d, expected all 0",
                  pkt_data, pkt_valid, pkt_last, err_pulse, err_code);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %0b, expected 0", busy);
      end
      rst = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      logic [7:0] pre[$]  = '{8'h00, 8'hFF};
      logic [7:0] frm[$]  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
      send_list(pre);
      idle(10);
      send_list(frm);
      checks++;
      if (pkt_valid !== 1'b1 || pkt_data !== 8'h11 || pkt_last !== 1'b0) begin
         errors++;
         $display("FAIL basic_first_beat: got v=%0b d=%h l=%0b, expected v=1 d=11 l=0",
                  pkt_valid, pkt_data, pkt_last);
      end
      wait_idle(1'b0);
      checks++;
      if (got_beats.size() != exp_beats.size() || got_errs.size() != exp_errs.size()) begin
         errors++;
         $display("FAIL basic_counts: got %0d beats %0d errs, expected %0d beats %0d errs",
                  got_beats.size(), got_errs.size(), exp_beats.size(), exp_errs.size());
      end else begin
         foreach (exp_beats[i]) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin
               errors++;
               $display("FAIL basic_beat[%0d]: got %h, expected %h", i, got_beats[i], exp_beats[i]);
            end
         end
      end
      got_beats.delete(); exp_beats.delete(); got_errs.delete(); exp_errs.delete();
   endtask

   task automatic test_frame_errors();
      logic [7:0] f1[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
      logic [7:0] f2[$] = '{8'hA5, 8'h00};
      logic [7:0] f3[$] = '{8'hA5, 8'h11};
      logic [7:0] f4[$] = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
      logic [7:0] f5[$] = '{8'hA5, 8'h02};
      send_list(f1); idle(10);
      send_list(f2); idle(10);
      send_list(f3); idle(10);
      send_list(f4); wait_idle(1'b0);
      send_list(f5); idle(10);
      send_byte(8'h44, 1'b1);
      checks++;
      if (err_pulse !== 1'b1 || err_code !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL parity_now: got ep=%0b ec=%0d busy=%0b, expected ep=1 ec=0 busy=0",
                  err_pulse, err_code, busy);
      end
      idle(5);
      checks++;
      if (got_beats.size() != exp_beats.size() || got_errs.size() != exp_errs.size()) begin
         errors++;
         $display("FAIL errs_counts: got %0d beats %0d errs, expected %0d beats %0d errs",
                  got_beats.size(), got_errs.size(), exp_beats.size(), exp_errs.size());
      end else begin
         foreach (exp_beats[i]) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin
               errors++;
               $display("FAIL errs_beat[%0d]: got %h, expected %h", i, got_beats[i], exp_beats[i]);
            end
         end
         foreach (exp_errs[i]) begin
            checks++;
            if (got_errs[i] !== exp_errs[i]) begin
               errors++;
               $display("FAIL errs_code[%0d]: got %0d, expected %0d", i, got_errs[i], exp_errs[i]);
            end
         end
      end
      got_beats.delete(); exp_beats.delete(); got_errs.delete(); exp_errs.delete();
   endtask

   task automatic test_timeout();
      int n = 0;
      send_byte(8'hA5, 1'b0); idle(10);
      send_byte(8'h02, 1'b0); idle(10);
      send_byte(8'h11, 1'b0);
      for (int k = 1; k <= 80 && n == 0; k++) begin
         @(posedge clk);
         #1;
         if (err_pulse) n = k;
      end
      checks++;
      if (n != 64 || err_code !== 3'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_exact: got cycle=%0d code=%0d busy=%0b, expected cycle=64 code=3 busy=0",
                  n, err_code, busy);
      end
      m_in = 1'b0;
      exp_errs.push_back(3'd3);
      idle(5);
      // Next byte lands exactly on the expiry cycle and must win.
      send_byte(8'hA5, 1'b0); idle(10);
      send_byte(8'h02, 1'b0); idle(10);
      send_byte(8'h11, 1'b0); idle(63);
      send_byte(8'h22, 1'b0);
      checks++;
      if (err_pulse !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_expiry_byte: got ep=%0b busy=%0b, expected ep=0 busy=1", err_pulse, busy);
      end
      idle(10);
      send_byte(8'hCB, 1'b0);
      wait_idle(1'b0);
      checks++;
      if (got_beats.size() != exp_beats.size() || got_errs.size() != exp_errs.size()) begin
         errors++;
         $display("FAIL timeout_counts: got %0d beats %0d errs, expected %0d beats %0d errs",
                  got_beats.size(), got_errs.size(), exp_beats.size(), exp_errs.size());
      end else begin
         foreach (exp_beats[i]) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin
               errors++;
               $display("FAIL timeout_beat[%0d]: got %h, expected %h", i, got_beats[i], exp_beats[i]);
            end
         end
      end
      got_beats.delete(); exp_beats.delete(); got_errs.delete(); exp_errs.delete();
   endtask

   task automatic test_overrun();
      logic [7:0] frm[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
      pkt_ready = 1'b0;
      send_list(frm);
      idle(3);
      send_byte(8'h77, 1'b0);
      checks++;
      if (err_pulse !== 1'b1 || err_code !== 3'd4 || pkt_valid !== 1'b1 || pkt_data !== 8'h11) begin
         errors++;
         $display("FAIL overrun_now: got ep=%0b ec=%0d v=%0b d=%h, expected ep=1 ec=4 v=1 d=11",
                  err_pulse, err_code, pkt_valid, pkt_data);
      end
      exp_errs.push_back(3'd4);
      wait_idle(1'b1);
      checks++;
      if (got_beats.size() != exp_beats.size() || got_errs.size() != exp_errs.size()) begin
         errors++;
         $display("FAIL overrun_counts: got %0d beats %0d errs, expected %0d beats %0d errs",
                  got_beats.size(), got_errs.size(), exp_beats.size(), exp_errs.size());
      end else begin
         foreach (exp_beats[i]) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin
               errors++;
               $display("FAIL overrun_beat[%0d]: got %h, expected %h", i, got_beats[i], exp_beats[i]);
            end
         end
      end
      got_beats.delete(); exp_beats.delete(); got_errs.delete(); exp_errs.delete();
   endtask

   task automatic test_reset_mid();
      logic [7:0] part[$] = '{8'hA5, 8'h04, 8'h01, 8'h02};
      logic [7:0] frm[$]  = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
      send_list(part);
      idle(3);
      rst = 1'b0;
      #1;
      checks++;
      if ({pkt_data, pkt_valid, pkt_last, err_pulse, err_code, busy} !== 15'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got d=%h v=%0b l=%0b ep=%0b ec=%0d busy=%0b, expected all 0",
                  pkt_data, pkt_valid, pkt_last, err_pulse, err_code, busy);
      end
      m_in = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(2);
      send_list(frm);
      wait_idle(1'b1);
      checks++;
      if (got_beats.size() != exp_beats.size() || got_errs.size() != exp_errs.size()) begin
         errors++;
         $display("FAIL reset_mid_counts: got %0d beats %0d errs, expected %0d beats %0d errs",
                  got_beats.size(), got_errs.size(), exp_beats.size(), exp_errs.size());
      end else begin
         foreach (exp_beats[i]) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin
               errors++;
               $display("FAIL reset_mid_beat[%0d]: got %h, expected %h", i, got_beats[i], exp_beats[i]);
            end
         end
      end
      got_beats.delete(); exp_beats.delete(); got_errs.delete(); exp_errs.delete();
   endtask

   task automatic test_random();
      for (int f = 0; f < 20; f++) begin
         logic [7:0] q[$];
         logic [7:0] s;
         logic [7:0] g;
         int len;
         int mode;
         int perr_pos;
         bit stop;
         if ($urandom_range(0, 1) == 1) begin
            g = 8'($urandom_range(0, 255));
            send_byte(g, g == 8'hA5);
            idle(10);
         end
         len  = $urandom_range(1, 16);
         mode = $urandom_range(0, 3);
         q.delete();
         q.push_back(8'(len));
         s = 8'(len);
         for (int i = 0; i < len; i++) begin
            q.push_back(8'($urandom_range(0, 255)));
            s = s + q[q.size() - 1];
         end
         q.push_back(8'd0 - s);
         if (mode == 2) q[q.size() - 1] = q[q.size() - 1] ^ 8'($urandom_range(1, 255));
         perr_pos = (mode == 3) ? $urandom_range(0, len + 1) : -1;
         send_byte(8'hA5, 1'b0);
         idle($urandom_range(10, 20));
         stop = 1'b0;
         foreach (q[i]) begin
            if (!stop) begin
               send_byte(q[i], i == perr_pos);
               if (i == perr_pos || i == q.size() - 1) stop = 1'b1;
               else idle($urandom_range(10, 20));
            end
         end
         wait_idle(1'b1);
      end
      checks++;
      if (got_beats.size() != exp_beats.size() || got_errs.size() != exp_errs.size()) begin
         errors++;
         $display("FAIL random_counts: got %0d beats %0d errs, expected %0d beats %0d errs",
                  got_beats.size(), got_errs.size(), exp_beats.size(), exp_errs.size());
      end else begin
         foreach (exp_beats[i]) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin
               errors++;
               $display("FAIL random_beat[%0d]: got %h, expected %h", i, got_beats[i], exp_beats[i]);
            end
         end
         foreach (exp_errs[i]) begin
            checks++;
            if (got_errs[i] !== exp_errs[i]) begin
               errors++;
               $display("FAIL random_code[%0d]: got %0d, expected %0d", i, got_errs[i], exp_errs[i]);
            end
         end
      end
      got_beats.delete(); exp_beats.delete(); got_errs.delete(); exp_errs.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame_errors();
      test_timeout();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
